// File: rtl/inst_fetch.sv
// Fetch stage: issues one instruction-bus read at a time and holds the returned word for decode.
// Optional alignment check enabled by defining INST_FETCH_ADEL_CHECK_EN.
module inst_fetch #(
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = {INST_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INST_W-1:0] pc_i,
  output logic              pc_en,
  input  logic              flush_i,
  output logic              inst_req,
  output logic [INST_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [INST_W-1:0] inst_rdata,
  input  logic              id_ready_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [INST_W-1:0] pc_o,
  output logic              excp_adel_o,
  output logic [2:0]        state_o
);

  // Bus handshake: a request transfers when inst_req & inst_addr_ok in the same
  // cycle; its read data transfers in a later cycle when inst_data_ok is high.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_DATA    = 3'd2,
    S_DISCARD = 3'd3,
    S_OUT     = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [INST_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              misaligned;

`ifdef INST_FETCH_ADEL_CHECK_EN
  logic adel_q, adel_d;
  assign misaligned = (pc_i[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    inst_d   = inst_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    inst_req = 1'b0;
`ifdef INST_FETCH_ADEL_CHECK_EN
    adel_d   = adel_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (!flush_i && misaligned) begin
          // Misaligned PC never reaches the bus; a NOP carrying the exception is handed to decode.
          state_d = S_OUT;
          valid_d = 1'b1;
          inst_d  = NOP_INST;
          pc_d    = pc_i;
`ifdef INST_FETCH_ADEL_CHECK_EN
          adel_d  = 1'b1;
`endif
        end else begin
          inst_req = ~flush_i;
          if (!flush_i && inst_addr_ok) begin
            state_d = S_DATA;
            pc_d    = pc_i;
          end
        end
      end
      S_DATA: begin
        if (inst_data_ok) begin
          if (flush_i) begin
            state_d = S_REQ;
          end else begin
            state_d = S_OUT;
            inst_d  = inst_rdata;
            valid_d = 1'b1;
          end
        end else if (flush_i) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        // Swallow the response of the squashed request before issuing again.
        if (inst_data_ok) state_d = S_REQ;
      end
      S_OUT: begin
        if (flush_i || id_ready_i) begin
          state_d = S_REQ;
          valid_d = 1'b0;
          inst_d  = NOP_INST;
`ifdef INST_FETCH_ADEL_CHECK_EN
          adel_d  = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      inst_q  <= NOP_INST;
      pc_q    <= {INST_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

`ifdef INST_FETCH_ADEL_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) adel_q <= 1'b0;
    else        adel_q <= adel_d;
  end
  assign excp_adel_o = adel_q;
`else
  assign excp_adel_o = 1'b0;
`endif

  assign pc_en        = (inst_req & inst_addr_ok) | flush_i;
  assign inst_addr    = pc_i;
  assign inst_valid_o = valid_q;
  assign inst_o       = inst_q;
  assign pc_o         = pc_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a randomized run
// against a transaction-level model of the fetch/bus/decode rules.
module tb_inst_fetch;
  localparam int W = 32;
  localparam logic [W-1:0] NOP = 32'h0000_0000;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] pc_i;
  logic         pc_en;
  logic         flush_i;
  logic         inst_req;
  logic [W-1:0] inst_addr;
  logic         inst_addr_ok;
  logic         inst_data_ok;
  logic [W-1:0] inst_rdata;
  logic         id_ready_i;
  logic         inst_valid_o;
  logic [W-1:0] inst_o;
  logic [W-1:0] pc_o;
  logic         excp_adel_o;
  logic [2:0]   state_o;

  int vectors = 0;
  int miscompares = 0;

  inst_fetch #(.INST_W(W), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .pc_en(pc_en), .flush_i(flush_i),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .id_ready_i(id_ready_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .pc_o(pc_o),
    .excp_adel_o(excp_adel_o), .state_o(state_o)
  );

  // Clock and time limit
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "time limit");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    flush_i = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    id_ready_i = 1'b0; inst_rdata = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc_i = 32'hbfc00000; idle_in();
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (inst_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b expected 0", inst_req); end
    vectors++; if (inst_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b expected 0", inst_valid_o); end
    vectors++; if (inst_o !== NOP) begin miscompares++; $display("FAIL rst_inst: got %h expected %h", inst_o, NOP); end
    vectors++; if (pc_o !== 32'h0) begin miscompares++; $display("FAIL rst_pc: got %h expected 0", pc_o); end
    vectors++; if (excp_adel_o !== 1'b0) begin miscompares++; $display("FAIL rst_adel: got %b expected 0", excp_adel_o); end
    rst_n = 1'b1;
    #1;
    vectors++; if (inst_req !== 1'b0) begin miscompares++; $display("FAIL cyc1_req: got %b expected 0", inst_req); end
    tick();
    inst_addr_ok = 1'b1;
    #1;
    vectors++; if (inst_req !== 1'b1) begin miscompares++; $display("FAIL cyc2_req: got %b expected 1", inst_req); end
    vectors++; if (inst_addr !== 32'hbfc00000) begin miscompares++; $display("FAIL cyc2_addr: got %h expected bfc00000", inst_addr); end
    vectors++; if (pc_en !== 1'b1) begin miscompares++; $display("FAIL cyc2_pc_en: got %b expected 1", pc_en); end
    tick();
    inst_addr_ok = 1'b0; pc_i = 32'hbfc00004; inst_data_ok = 1'b1; inst_rdata = 32'h24080001;
    #1;
    vectors++; if (inst_req !== 1'b0) begin miscompares++; $display("FAIL cyc3_req: got %b expected 0", inst_req); end
    tick();
    inst_data_ok = 1'b0; id_ready_i = 1'b1;
    #1;
    vectors++; if (inst_valid_o !== 1'b1) begin miscompares++; $display("FAIL first_valid: got %b expected 1", inst_valid_o); end
    vectors++; if (inst_o !== 32'h24080001) begin miscompares++; $display("FAIL first_inst: got %h expected 24080001", inst_o); end
    vectors++; if (pc_o !== 32'hbfc00000) begin miscompares++; $display("FAIL first_pc: got %h expected bfc00000", pc_o); end
    vectors++; if (pc_en !== 1'b0) begin miscompares++; $display("FAIL first_pc_en: got %b expected 0", pc_en); end
    tick();
    id_ready_i = 1'b0;
  endtask

  task automatic test_stall();
    pc_i = 32'h0000_1000; inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0; pc_i = 32'h0000_1004; inst_data_ok = 1'b1; inst_rdata = 32'h1111_2222;
    tick();
    inst_data_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pc_i = $urandom; inst_addr_ok = 1'($urandom_range(0, 1));
      #1;
      vectors++; if (inst_valid_o !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, inst_valid_o); end
      vectors++; if (inst_o !== 32'h1111_2222) begin miscompares++; $display("FAIL stall_inst[%0d]: got %h expected 11112222", i, inst_o); end
      vectors++; if (pc_o !== 32'h0000_1000) begin miscompares++; $display("FAIL stall_pc[%0d]: got %h expected 00001000", i, pc_o); end
      vectors++; if (inst_req !== 1'b0) begin miscompares++; $display("FAIL stall_req[%0d]: got %b expected 0", i, inst_req); end
      vectors++; if (pc_en !== 1'b0) begin miscompares++; $display("FAIL stall_pc_en[%0d]: got %b expected 0", i, pc_en); end
      tick();
    end
    inst_addr_ok = 1'b0; pc_i = 32'h0000_1004; id_ready_i = 1'b1;
    tick();
    id_ready_i = 1'b0;
    #1;
    vectors++; if (inst_req !== 1'b1) begin miscompares++; $display("FAIL stall_next_req: got %b expected 1", inst_req); end
    vectors++; if (inst_valid_o !== 1'b0) begin miscompares++; $display("FAIL stall_released: got %b expected 0", inst_valid_o); end
    vectors++; if (inst_o !== NOP) begin miscompares++; $display("FAIL stall_nop: got %h expected %h", inst_o, NOP); end
  endtask

  task automatic test_flush_data();
    pc_i = 32'h0000_2000; inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0; pc_i = 32'h0000_2004; flush_i = 1'b1;
    #1;
    vectors++; if (pc_en !== 1'b1) begin miscompares++; $display("FAIL fl_pc_en: got %b expected 1", pc_en); end
    vectors++; if (inst_req !== 1'b0) begin miscompares++; $display("FAIL fl_req: got %b expected 0", inst_req); end
    tick();
    flush_i = 1'b0; pc_i = 32'h0000_8000;
    for (int i = 0; i < 3; i++) begin
      inst_data_ok = (i == 2); inst_rdata = (i == 2) ? 32'hdeadbeef : 32'h0;
      #1;
      vectors++; if (inst_req !== 1'b0) begin miscompares++; $display("FAIL disc_req[%0d]: got %b expected 0", i, inst_req); end
      vectors++; if (inst_valid_o !== 1'b0) begin miscompares++; $display("FAIL disc_valid[%0d]: got %b expected 0", i, inst_valid_o); end
      tick();
    end
    inst_data_ok = 1'b0;
    #1;
    vectors++; if (inst_req !== 1'b1) begin miscompares++; $display("FAIL disc_next_req: got %b expected 1", inst_req); end
    vectors++; if (inst_valid_o !== 1'b0) begin miscompares++; $display("FAIL disc_no_valid: got %b expected 0", inst_valid_o); end
    vectors++; if (inst_o === 32'hdeadbeef) begin miscompares++; $display("FAIL disc_data: got %h expected not deadbeef", inst_o); end
  endtask

  task automatic test_flush_same_cycle();
    pc_i = 32'h0000_3000; inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0; flush_i = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hcafef00d; pc_i = 32'h0000_9000;
    #1;
    vectors++; if (pc_en !== 1'b1) begin miscompares++; $display("FAIL same_pc_en: got %b expected 1", pc_en); end
    tick();
    idle_in();
    #1;
    vectors++; if (inst_valid_o !== 1'b0) begin miscompares++; $display("FAIL same_valid: got %b expected 0", inst_valid_o); end
    vectors++; if (inst_req !== 1'b1) begin miscompares++; $display("FAIL same_req: got %b expected 1", inst_req); end
    vectors++; if (inst_o !== NOP) begin miscompares++; $display("FAIL same_inst: got %h expected %h", inst_o, NOP); end
  endtask

  task automatic test_addr_wait();
    logic [W-1:0] p;
    for (int i = 0; i < 4; i++) begin
      pc_i = $urandom & 32'hffff_fffc;
      #1;
      vectors++; if (inst_req !== 1'b1) begin miscompares++; $display("FAIL wait_req[%0d]: got %b expected 1", i, inst_req); end
      vectors++; if (inst_addr !== pc_i) begin miscompares++; $display("FAIL wait_addr[%0d]: got %h expected %h", i, inst_addr, pc_i); end
      vectors++; if (pc_en !== 1'b0) begin miscompares++; $display("FAIL wait_pc_en[%0d]: got %b expected 0", i, pc_en); end
      tick();
    end
    p = $urandom & 32'hffff_fffc;
    pc_i = p; inst_addr_ok = 1'b1;
    #1;
    vectors++; if (pc_en !== 1'b1) begin miscompares++; $display("FAIL wait_accept: got %b expected 1", pc_en); end
    tick();
    inst_addr_ok = 1'b0; pc_i = p + 4; inst_data_ok = 1'b1; inst_rdata = 32'h3c1d_0001;
    tick();
    inst_data_ok = 1'b0; id_ready_i = 1'b1;
    vectors++; if (pc_o !== p) begin miscompares++; $display("FAIL wait_pc_o: got %h expected %h", pc_o, p); end
    vectors++; if (inst_o !== 32'h3c1d_0001) begin miscompares++; $display("FAIL wait_inst: got %h expected 3c1d0001", inst_o); end
    tick();
    id_ready_i = 1'b0;
  endtask

  task automatic test_flush_out();
    pc_i = 32'h0000_4000; inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h0123_4567;
    tick();
    inst_data_ok = 1'b0; flush_i = 1'b1; pc_i = 32'h0000_a000;
    #1;
    vectors++; if (pc_en !== 1'b1) begin miscompares++; $display("FAIL out_fl_pc_en: got %b expected 1", pc_en); end
    tick();
    flush_i = 1'b0;
    #1;
    vectors++; if (inst_valid_o !== 1'b0) begin miscompares++; $display("FAIL out_fl_valid: got %b expected 0", inst_valid_o); end
    vectors++; if (inst_o !== NOP) begin miscompares++; $display("FAIL out_fl_inst: got %h expected %h", inst_o, NOP); end
    vectors++; if (inst_req !== 1'b1) begin miscompares++; $display("FAIL out_fl_req: got %b expected 1", inst_req); end
  endtask

  task automatic test_protocol_error();
    inst_data_ok = 1'b1; inst_rdata = 32'hbad0_0bad;
    tick();
    inst_data_ok = 1'b0;
    #1;
    vectors++; if (inst_valid_o !== 1'b0) begin miscompares++; $display("FAIL stray_valid: got %b expected 0", inst_valid_o); end
    vectors++; if (inst_req !== 1'b1) begin miscompares++; $display("FAIL stray_req: got %b expected 1", inst_req); end
  endtask

  task automatic test_async_reset();
    pc_i = 32'h0000_5000; inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h7777_8888;
    tick();
    inst_data_ok = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (inst_valid_o !== 1'b0) begin miscompares++; $display("FAIL arst_valid: got %b expected 0", inst_valid_o); end
    vectors++; if (inst_o !== NOP) begin miscompares++; $display("FAIL arst_inst: got %h expected %h", inst_o, NOP); end
    vectors++; if (pc_o !== 32'h0) begin miscompares++; $display("FAIL arst_pc: got %h expected 0", pc_o); end
    tick();
    rst_n = 1'b1;
    #1;
    vectors++; if (inst_req !== 1'b0) begin miscompares++; $display("FAIL arst_cyc1_req: got %b expected 0", inst_req); end
    tick();
    vectors++; if (inst_req !== 1'b1) begin miscompares++; $display("FAIL arst_cyc2_req: got %b expected 1", inst_req); end
  endtask

  task automatic test_misaligned();
    pc_i = 32'hbfc00002;
`ifdef INST_FETCH_ADEL_CHECK_EN
    #1;
    vectors++; if (inst_req !== 1'b0) begin miscompares++; $display("FAIL adel_req: got %b expected 0", inst_req); end
    vectors++; if (pc_en !== 1'b0) begin miscompares++; $display("FAIL adel_pc_en: got %b expected 0", pc_en); end
    tick();
    vectors++; if (inst_valid_o !== 1'b1) begin miscompares++; $display("FAIL adel_valid: got %b expected 1", inst_valid_o); end
    vectors++; if (excp_adel_o !== 1'b1) begin miscompares++; $display("FAIL adel_flag: got %b expected 1", excp_adel_o); end
    vectors++; if (pc_o !== 32'hbfc00002) begin miscompares++; $display("FAIL adel_pc: got %h expected bfc00002", pc_o); end
    vectors++; if (inst_o !== 32'h0) begin miscompares++; $display("FAIL adel_inst: got %h expected 0", inst_o); end
    id_ready_i = 1'b1;
    tick();
    id_ready_i = 1'b0; pc_i = 32'hbfc00380;
    #1;
    vectors++; if (excp_adel_o !== 1'b0) begin miscompares++; $display("FAIL adel_clear: got %b expected 0", excp_adel_o); end
    vectors++; if (inst_req !== 1'b1) begin miscompares++; $display("FAIL adel_next_req: got %b expected 1", inst_req); end
`else
    inst_addr_ok = 1'b1;
    #1;
    vectors++; if (inst_req !== 1'b1) begin miscompares++; $display("FAIL mis_req: got %b expected 1", inst_req); end
    vectors++; if (inst_addr !== 32'hbfc00002) begin miscompares++; $display("FAIL mis_addr: got %h expected bfc00002", inst_addr); end
    tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h2409_0002;
    tick();
    inst_data_ok = 1'b0; id_ready_i = 1'b1;
    vectors++; if (excp_adel_o !== 1'b0) begin miscompares++; $display("FAIL mis_adel: got %b expected 0", excp_adel_o); end
    vectors++; if (pc_o !== 32'hbfc00002) begin miscompares++; $display("FAIL mis_pc: got %h expected bfc00002", pc_o); end
    vectors++; if (inst_o !== 32'h2409_0002) begin miscompares++; $display("FAIL mis_inst: got %h expected 24090002", inst_o); end
    tick();
    id_ready_i = 1'b0;
`endif
  endtask

  // Randomized run: scoreboard of accepted-and-not-flushed fetch PCs; the
  // returned word for a PC is PC ^ KEY so data is checkable from the PC alone.
  task automatic test_random();
    localparam logic [W-1:0] KEY = 32'h5a5a_0000;
    logic [W-1:0] exp_q[$];
    logic         outstanding = 1'b0;
    logic         dropped = 1'b0;
    logic [W-1:0] out_pc = '0;
    int           delay = 0;
    int           delivered = 0;
    logic         req_s;
    for (int cyc = 0; cyc < 800; cyc++) begin
      flush_i      = ($urandom_range(0, 11) == 0);
      id_ready_i   = 1'($urandom_range(0, 1));
      pc_i         = $urandom & 32'hffff_fffc;
      inst_data_ok = outstanding && (delay == 0);
      inst_rdata   = inst_data_ok ? (out_pc ^ KEY) : $urandom;
      #1;
      req_s = inst_req;
      inst_addr_ok = req_s && ($urandom_range(0, 2) != 0);
      #1;
      vectors++; if (req_s !== (!outstanding && exp_q.size() == 0 && !flush_i)) begin miscompares++; $display("FAIL rnd_req@%0d: got %b expected %b", cyc, req_s, (!outstanding && exp_q.size() == 0 && !flush_i)); end
      vectors++; if (pc_en !== ((req_s & inst_addr_ok) | flush_i)) begin miscompares++; $display("FAIL rnd_pc_en@%0d: got %b expected %b", cyc, pc_en, (req_s & inst_addr_ok) | flush_i); end
      vectors++; if (inst_addr !== pc_i) begin miscompares++; $display("FAIL rnd_addr@%0d: got %h expected %h", cyc, inst_addr, pc_i); end
      vectors++; if (inst_valid_o !== (exp_q.size() != 0)) begin miscompares++; $display("FAIL rnd_valid@%0d: got %b expected %b", cyc, inst_valid_o, exp_q.size() != 0); end
      vectors++; if (excp_adel_o !== 1'b0) begin miscompares++; $display("FAIL rnd_adel@%0d: got %b expected 0", cyc, excp_adel_o); end
      if (exp_q.size() != 0) begin
        vectors++; if (inst_o !== (exp_q[0] ^ KEY)) begin miscompares++; $display("FAIL rnd_inst@%0d: got %h expected %h", cyc, inst_o, exp_q[0] ^ KEY); end
        vectors++; if (pc_o !== exp_q[0]) begin miscompares++; $display("FAIL rnd_pc@%0d: got %h expected %h", cyc, pc_o, exp_q[0]); end
      end else begin
        vectors++; if (inst_o !== NOP) begin miscompares++; $display("FAIL rnd_nop@%0d: got %h expected %h", cyc, inst_o, NOP); end
      end
      if (exp_q.size() != 0 && (flush_i || id_ready_i)) begin
        if (!flush_i) delivered++;
        void'(exp_q.pop_front());
      end
      if (outstanding) begin
        if (inst_data_ok) begin
          if (!dropped && !flush_i) exp_q.push_back(out_pc);
          outstanding = 1'b0;
        end else begin
          if (flush_i) dropped = 1'b1;
          delay--;
        end
      end
      if (req_s && inst_addr_ok) begin
        outstanding = 1'b1; out_pc = pc_i; dropped = 1'b0; delay = $urandom_range(0, 3);
      end
      tick();
    end
    idle_in();
    vectors++; if (delivered < 30) begin miscompares++; $display("FAIL rnd_progress: got %0d delivered expected at least 30", delivered); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_flush_data();
    test_flush_same_cycle();
    test_addr_wait();
    test_flush_out();
    test_protocol_error();
    test_async_reset();
    test_misaligned();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
